// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / memory-wait / branch-flush hazard controller
module hazard_stall_unit #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [18:0]      IF_ID_instruction,
   input  logic [18:0]      ID_EX_instruction,
   input  logic [18:0]      EX_MEM_instruction,
   input  logic             mem_ready,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_write,
   output logic             ID_EX_bubble,
   output logic             EX_MEM_write,
   output logic             MEM_WB_bubble,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;
   localparam logic [4:0] OP_LW = 5'b10000;
   localparam logic [4:0] OP_SW = 5'b10001;

   logic [0:0]      state, state_nxt;
   logic [WC_W-1:0] wait_cnt, wait_nxt;

   logic [4:0] id_op;
   logic [2:0] id_dst, id_a, id_b, ex_dst, mem_dst;
   logic       id_lw, id_sw, id_alu, id_imm;
   logic       reads_a, reads_b, reads_d;
   logic       ex_lw, mem_lw, mem_sw;
   logic       hit_ex, hit_mem, load_use, freeze, do_branch, do_lu;
   logic       unused_bits;

   assign id_op   = IF_ID_instruction[18:14];
   assign id_dst  = IF_ID_instruction[13:11];
   assign id_a    = IF_ID_instruction[10:8];
   assign id_b    = IF_ID_instruction[7:5];
   assign ex_dst  = ID_EX_instruction[13:11];
   assign mem_dst = EX_MEM_instruction[13:11];
   assign unused_bits = ^{IF_ID_instruction[4:0], ID_EX_instruction[10:0],
                          EX_MEM_instruction[10:0]};

   assign id_alu  = ~IF_ID_instruction[18];
   assign id_imm  = IF_ID_instruction[17];
   assign id_lw   = (id_op == OP_LW);
   assign id_sw   = (id_op == OP_SW);
   assign ex_lw   = (ID_EX_instruction[18:14] == OP_LW);
   assign mem_lw  = (EX_MEM_instruction[18:14] == OP_LW);
   assign mem_sw  = (EX_MEM_instruction[18:14] == OP_SW);

   assign reads_a = id_alu | id_lw | id_sw;
   assign reads_b = id_alu & ~id_imm;
   assign reads_d = id_sw;

   assign hit_ex = ex_lw && (ex_dst != 3'd0) &&
                   ((reads_a && id_a == ex_dst) ||
                    (reads_b && id_b == ex_dst) ||
                    (reads_d && id_dst == ex_dst));

   // A loaded value cannot be forwarded into the address/store-data path of a lw/sw in EX.
   assign hit_mem = mem_lw && (mem_dst != 3'd0) && (id_lw || id_sw) &&
                    ((id_a == mem_dst) || (id_sw && id_dst == mem_dst));

   assign load_use  = hit_ex | hit_mem;
   assign freeze    = (mem_lw | mem_sw) & ~mem_ready;
   assign do_branch = ~freeze & branch_taken;
   assign do_lu     = ~freeze & ~branch_taken & load_use;

   always_comb begin
      pc_write      = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_write   = 1'b1;
      ID_EX_bubble  = 1'b0;
      EX_MEM_write  = 1'b1;
      MEM_WB_bubble = 1'b0;
      if (rst_n) begin
         if (freeze) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
         end else if (do_branch) begin
            IF_ID_flush   = 1'b1;
            ID_EX_bubble  = 1'b1;
         end else if (do_lu) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_bubble  = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         ST_RUN: begin
            if (freeze) begin
               state_nxt = ST_MEM_WAIT;
               wait_nxt  = WC_W'(1);
            end
         end
         default: begin
            if (mem_ready) begin
               state_nxt = ST_RUN;
               wait_nxt  = '0;
            end else if (wait_cnt != WC_W'(MEM_TIMEOUT)) begin
               wait_nxt  = wait_cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RUN;
         wait_cnt     <= '0;
         mem_error    <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (wait_nxt == WC_W'(MEM_TIMEOUT))
            mem_error <= 1'b1;
         if ((freeze | do_lu) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
         if (do_branch && (flush_count != '1))
            flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

   localparam int MEM_TIMEOUT = 15;
   localparam int CNT_W       = 16;
   localparam int MAXC        = (1 << CNT_W) - 1;

   localparam logic [4:0] ALU = 5'b00000;
   localparam logic [4:0] IMM = 5'b01000;
   localparam logic [4:0] LW  = 5'b10000;
   localparam logic [4:0] SW  = 5'b10001;
   localparam logic [4:0] OTH = 5'b11000;

   // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
   localparam logic [6:0] C_RUN = 7'b1101010;
   localparam logic [6:0] C_FRZ = 7'b0000001;
   localparam logic [6:0] C_BR  = 7'b1111110;
   localparam logic [6:0] C_LU  = 7'b0001110;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [18:0] if_id = '0, id_ex = '0, ex_mem = '0;
   logic mem_ready = 1'b1, branch_taken = 1'b0;
   logic pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble;
   logic EX_MEM_write, MEM_WB_bubble, mem_error;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   logic [6:0] ctrl;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_stall_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_instruction(if_id), .ID_EX_instruction(id_ex), .EX_MEM_instruction(ex_mem),
      .mem_ready(mem_ready), .branch_taken(branch_taken),
      .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble), .EX_MEM_write(EX_MEM_write),
      .MEM_WB_bubble(MEM_WB_bubble), .mem_error(mem_error),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   assign ctrl = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
                  EX_MEM_write, MEM_WB_bubble};

   function automatic logic [18:0] mk(input logic [4:0] op, input int d, input int a, input int b);
      logic [2:0] d3, a3, b3;
      d3 = 3'(d); a3 = 3'(a); b3 = 3'(b);
      return {op, d3, a3, b3, 5'b00000};
   endfunction

   // ---------------- reference model ----------------
   function automatic bit m_freeze(input logic [18:0] m, input logic mr);
      return (m[18:14] == LW || m[18:14] == SW) && !mr;
   endfunction

   function automatic bit m_load_use(input logic [18:0] i, input logic [18:0] e, input logic [18:0] m);
      int rd[$];
      bit is_mem;
      is_mem = (i[18:14] == LW) || (i[18:14] == SW);
      if (!i[18] || is_mem) rd.push_back(int'(i[10:8]));
      if (!i[18] && !i[17]) rd.push_back(int'(i[7:5]));
      if (i[18:14] == SW) rd.push_back(int'(i[13:11]));
      if (e[18:14] == LW && e[13:11] != 0)
         foreach (rd[k]) if (rd[k] == int'(e[13:11])) return 1;
      if (m[18:14] == LW && m[13:11] != 0 && is_mem)
         if (i[10:8] == m[13:11] || (i[18:14] == SW && i[13:11] == m[13:11])) return 1;
      return 0;
   endfunction

   function automatic logic [6:0] m_ctrl(input logic [18:0] i, input logic [18:0] e,
                                         input logic [18:0] m, input logic mr, input logic br);
      if (m_freeze(m, mr)) return C_FRZ;
      if (br) return C_BR;
      if (m_load_use(i, e, m)) return C_LU;
      return C_RUN;
   endfunction

   bit m_waiting;
   int m_consec, m_stall, m_flush;
   bit m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_waiting <= 0; m_consec <= 0; m_err <= 0; m_stall <= 0; m_flush <= 0;
      end else begin
         logic [6:0] c;
         bit nw;
         int nc;
         c = m_ctrl(if_id, id_ex, ex_mem, mem_ready, branch_taken);
         nw = m_waiting ? !mem_ready : m_freeze(ex_mem, mem_ready);
         nc = nw ? (m_waiting ? m_consec + 1 : 1) : 0;
         m_waiting <= nw;
         m_consec  <= nc;
         if (nc >= MEM_TIMEOUT) m_err <= 1;
         if ((c == C_FRZ || c == C_LU) && m_stall < MAXC) m_stall <= m_stall + 1;
         if (c == C_BR && m_flush < MAXC) m_flush <= m_flush + 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [18:0] i, input logic [18:0] e, input logic [18:0] m,
                        input logic mr, input logic br);
      @(negedge clk);
      if_id = i; id_ex = e; ex_mem = m; mem_ready = mr; branch_taken = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      if_id = mk(ALU, 1, 2, 3); id_ex = mk(LW, 2, 0, 0);
      ex_mem = mk(SW, 0, 0, 0); mem_ready = 1'b0; branch_taken = 1'b1;
      #1;
      chk("reset_ctrl", 32'(ctrl), 32'(C_RUN));
      chk("reset_err", 32'(mem_error), 32'd0);
      chk("reset_stall", 32'(stall_cycles), 32'd0);
      @(negedge clk);
      if_id = '0; id_ex = '0; ex_mem = '0; mem_ready = 1'b1; branch_taken = 1'b0;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [18:0] ifid, idex, exmem;
      logic mr, br;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[16];
   logic [18:0] nop;

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      nop = '0;
      tbl[0]  = '{nop, nop, nop, 1, 0, C_RUN};
      tbl[1]  = '{mk(ALU, 1, 3, 0), mk(LW, 3, 0, 0), nop, 1, 0, C_LU};
      tbl[2]  = '{mk(ALU, 1, 0, 3), mk(LW, 3, 0, 0), nop, 1, 0, C_LU};
      tbl[3]  = '{mk(IMM, 1, 0, 3), mk(LW, 3, 0, 0), nop, 1, 0, C_RUN};
      tbl[4]  = '{mk(ALU, 1, 0, 0), mk(LW, 0, 0, 0), nop, 1, 0, C_RUN};
      tbl[5]  = '{mk(SW, 2, 0, 0),  mk(LW, 2, 0, 0), nop, 1, 0, C_LU};
      tbl[6]  = '{mk(ALU, 1, 3, 0), mk(SW, 3, 0, 0), nop, 1, 0, C_RUN};
      tbl[7]  = '{mk(LW, 1, 4, 0),  nop, mk(LW, 4, 0, 0), 1, 0, C_LU};
      tbl[8]  = '{mk(ALU, 1, 4, 4), nop, mk(LW, 4, 0, 0), 1, 0, C_RUN};
      tbl[9]  = '{mk(SW, 4, 1, 0),  nop, mk(LW, 4, 0, 0), 1, 0, C_LU};
      tbl[10] = '{mk(SW, 1, 2, 4),  nop, mk(LW, 4, 0, 0), 1, 0, C_RUN};
      tbl[11] = '{nop, nop, mk(SW, 1, 2, 0), 0, 0, C_FRZ};
      tbl[12] = '{mk(ALU, 1, 3, 0), mk(LW, 3, 0, 0), mk(LW, 5, 0, 0), 0, 1, C_FRZ};
      tbl[13] = '{mk(ALU, 1, 3, 0), mk(LW, 3, 0, 0), nop, 1, 1, C_BR};
      tbl[14] = '{mk(OTH, 1, 3, 3), mk(LW, 3, 0, 0), nop, 1, 0, C_RUN};
      tbl[15] = '{mk(LW, 5, 1, 5),  mk(LW, 5, 0, 0), nop, 1, 0, C_RUN};

      do_reset();

      foreach (tbl[k]) begin
         drive(tbl[k].ifid, tbl[k].idex, tbl[k].exmem, tbl[k].mr, tbl[k].br);
         chk($sformatf("table_%0d", k), 32'(ctrl), 32'(tbl[k].exp));
         tick();
      end

      // lw -> dependent ALU: single stall
      do_reset();
      drive(mk(ALU, 1, 3, 0), mk(LW, 3, 0, 0), nop, 1, 0);
      chk("lu_alu_c1", 32'(ctrl), 32'(C_LU)); tick();
      drive(mk(ALU, 1, 3, 0), nop, mk(LW, 3, 0, 0), 1, 0);
      chk("lu_alu_c2", 32'(ctrl), 32'(C_RUN)); tick();
      chk("lu_alu_stall", 32'(stall_cycles), 32'd1);

      // lw -> dependent sw store data: two stalls, then r0 case none
      do_reset();
      drive(mk(SW, 2, 0, 0), mk(LW, 2, 0, 0), nop, 1, 0);
      chk("lu_sw_c1", 32'(ctrl), 32'(C_LU)); tick();
      drive(mk(SW, 2, 0, 0), nop, mk(LW, 2, 0, 0), 1, 0);
      chk("lu_sw_c2", 32'(ctrl), 32'(C_LU)); tick();
      drive(nop, mk(SW, 2, 0, 0), nop, 1, 0);
      chk("lu_sw_c3", 32'(ctrl), 32'(C_RUN)); tick();
      chk("lu_sw_stall", 32'(stall_cycles), 32'd2);
      drive(mk(SW, 0, 0, 0), mk(LW, 2, 0, 0), nop, 1, 0);
      chk("lu_sw_r0", 32'(ctrl), 32'(C_RUN)); tick();
      drive(mk(SW, 0, 0, 0), nop, mk(LW, 2, 0, 0), 1, 0);
      chk("lu_sw_r0_c2", 32'(ctrl), 32'(C_RUN)); tick();
      chk("lu_sw_r0_stall", 32'(stall_cycles), 32'd2);

      // three-cycle memory wait
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(nop, nop, mk(SW, 1, 2, 0), 0, 0);
         chk($sformatf("frz3_c%0d", c), 32'(ctrl), 32'(C_FRZ)); tick();
      end
      drive(nop, nop, mk(SW, 1, 2, 0), 1, 0);
      chk("frz3_release", 32'(ctrl), 32'(C_RUN)); tick();
      chk("frz3_stall", 32'(stall_cycles), 32'd3);
      chk("frz3_err", 32'(mem_error), 32'd0);

      // reset mid-freeze clears the wait count; then a full timeout
      do_reset();
      for (int c = 0; c < 10; c++) begin drive(nop, nop, mk(LW, 1, 2, 0), 0, 0); tick(); end
      do_reset();
      for (int c = 1; c <= 14; c++) begin drive(nop, nop, mk(LW, 1, 2, 0), 0, 1); tick(); end
      chk("tmo_err_14", 32'(mem_error), 32'd0);
      drive(nop, nop, mk(LW, 1, 2, 0), 0, 1);
      chk("tmo_frz_br_ignored", 32'(ctrl), 32'(C_FRZ)); tick();
      chk("tmo_err_15", 32'(mem_error), 32'd1);
      drive(nop, nop, mk(LW, 1, 2, 0), 0, 0); tick();
      drive(nop, nop, mk(LW, 1, 2, 0), 1, 0);
      chk("tmo_release", 32'(ctrl), 32'(C_RUN)); tick();
      chk("tmo_err_sticky", 32'(mem_error), 32'd1);
      chk("tmo_stall", 32'(stall_cycles), 32'd16);
      chk("tmo_flush", 32'(flush_count), 32'd0);
      do_reset();
      chk("tmo_err_cleared", 32'(mem_error), 32'd0);

      // branch coincident with load_use
      drive(mk(ALU, 1, 3, 0), mk(LW, 3, 0, 0), nop, 1, 1);
      chk("br_lu_ctrl", 32'(ctrl), 32'(C_BR)); tick();
      chk("br_lu_flush", 32'(flush_count), 32'd1);
      chk("br_lu_stall", 32'(stall_cycles), 32'd0);

      // randomized against the model, with occasional resets
      do_reset();
      for (int blk = 0; blk < 20; blk++) begin
         int p_low;
         p_low = $urandom_range(0, 95);
         for (int c = 0; c < 150; c++) begin
            logic [18:0] ri[3];
            logic rmr, rbr;
            for (int s = 0; s < 3; s++) begin
               logic [4:0] op;
               case ($urandom_range(0, 4))
                  0: op = {2'b00, 3'($urandom)};
                  1: op = {2'b01, 3'($urandom)};
                  2: op = LW;
                  3: op = SW;
                  default: op = {2'b11, 3'($urandom)};
               endcase
               ri[s] = {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                        3'($urandom_range(0, 3)), 5'($urandom)};
            end
            rmr = ($urandom_range(0, 99) >= p_low);
            rbr = ($urandom_range(0, 5) == 0);
            drive(ri[0], ri[1], ri[2], rmr, rbr);
            chk("rnd_ctrl", 32'(ctrl), 32'(m_ctrl(ri[0], ri[1], ri[2], rmr, rbr)));
            tick();
            chk("rnd_stall", 32'(stall_cycles), 32'(m_stall));
            chk("rnd_flush", 32'(flush_count), 32'(m_flush));
            chk("rnd_err", 32'(mem_error), 32'(m_err));
         end
         if (blk % 5 == 4) do_reset();
      end

      // stall counter saturation
      do_reset();
      for (int c = 0; c < MAXC - 1; c++) begin
         @(negedge clk);
         if_id = mk(ALU, 1, 1, 0); id_ex = mk(LW, 1, 0, 0); ex_mem = nop;
         mem_ready = 1'b1; branch_taken = 1'b0;
      end
      tick();
      chk("sat_fffe", 32'(stall_cycles), 32'h0000fffe);
      tick();
      chk("sat_ffff", 32'(stall_cycles), 32'h0000ffff);
      tick();
      chk("sat_hold", 32'(stall_cycles), 32'h0000ffff);
      chk("sat_flush", 32'(flush_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
